// File: rtl/count_checker_pkg.sv
// Shared types for the count_checker monitor: FSM encoding, direction
// codes and the per-sample step mode remembered for wrap qualification.
package count_checker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    TRACK,
    FAIL
  } cc_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // How the prediction for the next sample was formed.
  typedef struct packed {
    logic tm_reset;
    logic dir;
  } step_mode_t;

endpackage

// File: rtl/count_checker_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Holds at MAX once reached; clr has priority over inc.
module sat_counter #(
  parameter int            WD  = 8,
  parameter logic [WD-1:0] MAX = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [WD-1:0] q
);

  // Count register: reset, clear, then saturating increment.
  always_ff @(posedge clk) begin
    if (rst)                   q <= '0;
    else if (clr)              q <= '0;
    else if (inc && q != MAX)  q <= q + 1'b1;
  end

endmodule

// File: rtl/count_checker.sv
// count_checker: watches an up/down counter bus, predicts each next value
// from the observed value and the counter's test-mode controls, and reports
// mismatches, lock, wraps and a saturating error tally.
// Optional build macro COUNT_CHECKER_STOP_ON_ERR_EN: first mismatch in TRACK
// parks the FSM in FAIL with o_expected frozen until disable or reset.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int COUNT_WD   = 8,
  parameter int ERR_CNT_WD = 8,
  parameter int LOCK_LEN   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [COUNT_WD-1:0]   i_count,
  input  logic                  i_tm_reset,
  input  logic                  i_tm_direction,
  output logic                  o_locked,
  output logic                  o_error,
  output logic                  o_wrap,
  output logic [COUNT_WD-1:0]   o_expected,
  output logic [ERR_CNT_WD-1:0] o_err_count
);

  localparam int                    RUN_WD  = $clog2(LOCK_LEN + 1);
  localparam logic [COUNT_WD-1:0]   CNT_MAX = '1;
  localparam logic [RUN_WD-1:0]     RUN_MAX = RUN_WD'(LOCK_LEN);
  localparam logic [RUN_WD-1:0]     RUN_PRE = RUN_WD'(LOCK_LEN - 1);

  cc_state_e           state_q, state_d;
  logic [COUNT_WD-1:0] prev_q;
  step_mode_t          prev_mode_q;
  logic [RUN_WD-1:0]   run_q;

  logic [COUNT_WD-1:0] pred;
  logic                cmp_en;
  logic                match;
  logic                mismatch;
  logic                wrap_hit;
  logic                load_en;
  logic                run_inc;
  logic                run_clr;

  // Prediction and compare qualifiers for the sample at this edge.
  always_comb begin
    pred = '0;
    if (!i_tm_reset) begin
      if (i_tm_direction == DIR_UP) pred = i_count + 1'b1;
      else                          pred = i_count - 1'b1;
    end
    cmp_en   = i_enable && (state_q == TRACK);
    match    = (i_count == o_expected);
    mismatch = cmp_en && !match;
    // A wrap needs a matched +/-1 step off the extreme value; a step that
    // was predicted by tm_reset never counts.
    wrap_hit = 1'b0;
    if (cmp_en && match && !prev_mode_q.tm_reset) begin
      if (prev_mode_q.dir == DIR_UP) wrap_hit = (prev_q == CNT_MAX);
      else                           wrap_hit = (prev_q == '0);
    end
    load_en = i_enable && ((state_q == ACQ) || (state_q == TRACK));
`ifdef COUNT_CHECKER_STOP_ON_ERR_EN
    // Freeze the failing prediction.
    if (mismatch) load_en = 1'b0;
`endif
    run_inc = cmp_en && match;
    run_clr = !run_inc;
  end

  // Next-state logic; disable always falls back to IDLE.
  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ACQ;
        ACQ:     state_d = TRACK;
`ifdef COUNT_CHECKER_STOP_ON_ERR_EN
        TRACK:   state_d = match ? TRACK : FAIL;
`else
        TRACK:   state_d = TRACK;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Registered outputs and the last sample/mode used for the prediction.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_error     <= 1'b0;
      o_wrap      <= 1'b0;
      o_locked    <= 1'b0;
      o_expected  <= '0;
      prev_q      <= '0;
      prev_mode_q <= '0;
    end else begin
      o_error  <= mismatch;
      o_wrap   <= wrap_hit;
      o_locked <= run_inc && (run_q >= RUN_PRE);
      if (load_en) begin
        o_expected  <= pred;
        prev_q      <= i_count;
        prev_mode_q <= '{tm_reset: i_tm_reset, dir: i_tm_direction};
      end
    end
  end

  sat_counter #(
    .WD  (RUN_WD),
    .MAX (RUN_MAX)
  ) u_run_cnt (
    .clk (i_clk),
    .rst (i_rst),
    .clr (run_clr),
    .inc (run_inc),
    .q   (run_q)
  );

  sat_counter #(
    .WD  (ERR_CNT_WD),
    .MAX ('1)
  ) u_err_cnt (
    .clk (i_clk),
    .rst (i_rst),
    .clr (1'b0),
    .inc (mismatch),
    .q   (o_err_count)
  );

endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker: directed scenarios plus a randomized counter
// with glitches, checked every cycle against a behavioural model.
module tb_count_checker;

  localparam int W    = 8;
  localparam int EW   = 8;
  localparam int LL   = 4;
  localparam int MAXV = (1 << W) - 1;
  localparam int EMAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [W-1:0]  cnt = '0;
  logic          tmr = 1'b0;
  logic          dir = 1'b0;
  logic          o_locked, o_error, o_wrap;
  logic [W-1:0]  o_expected;
  logic [EW-1:0] o_err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_checker #(.COUNT_WD(W), .ERR_CNT_WD(EW), .LOCK_LEN(LL)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (en),
    .i_count        (cnt),
    .i_tm_reset     (tmr),
    .i_tm_direction (dir),
    .o_locked       (o_locked),
    .o_error        (o_error),
    .o_wrap         (o_wrap),
    .o_expected     (o_expected),
    .o_err_count    (o_err_count)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 waiting to acquire, 2 tracking, 3 failed.
  int mv = 0;
  int ph, m_exp, m_prev, m_run, m_err;
  bit m_prev_rst, m_prev_dir;
  bit e_lock, e_err, e_wrap;

  function automatic int predict(int c, bit r, bit d);
    if (r) return 0;
    if (d) return (c + MAXV) % (MAXV + 1);
    return (c + 1) % (MAXV + 1);
  endfunction

  always @(posedge clk) begin
    int c;
    c = int'(cnt);
    if (rst) begin
      ph = 0; m_exp = 0; m_prev = 0; m_run = 0; m_err = 0;
      m_prev_rst = 0; m_prev_dir = 0;
      e_lock = 0; e_err = 0; e_wrap = 0;
      mv = 1;
    end else begin
      e_lock = 0; e_err = 0; e_wrap = 0;
      if (!en) begin
        ph = 0; m_run = 0;
      end else if (ph == 0) begin
        ph = 1; m_run = 0;
      end else if (ph == 1) begin
        m_exp = predict(c, tmr, dir); m_prev = c; m_prev_rst = tmr; m_prev_dir = dir;
        m_run = 0; ph = 2;
      end else if (ph == 2) begin
        if (c == m_exp) begin
          m_run = (m_run + 1 > LL) ? LL : m_run + 1;
          e_lock = (m_run == LL);
          e_wrap = !m_prev_rst &&
                   ((!m_prev_dir && m_prev == MAXV && c == 0) ||
                    ( m_prev_dir && m_prev == 0 && c == MAXV));
          m_exp = predict(c, tmr, dir); m_prev = c; m_prev_rst = tmr; m_prev_dir = dir;
        end else begin
          e_err = 1; m_run = 0;
          if (m_err < EMAX) m_err++;
`ifdef COUNT_CHECKER_STOP_ON_ERR_EN
          ph = 3;
`else
          m_exp = predict(c, tmr, dir); m_prev = c; m_prev_rst = tmr; m_prev_dir = dir;
`endif
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (mv != 0) begin
      check("locked",    32'(o_locked),    32'(e_lock));
      check("error",     32'(o_error),     32'(e_err));
      check("wrap",      32'(o_wrap),      32'(e_wrap));
      check("expected",  32'(o_expected),  32'(m_exp));
      check("err_count", 32'(o_err_count), 32'(m_err));
    end
  end

  task automatic step(input bit e, input int c, input bit r, input bit d);
    en = e; cnt = W'(c); tmr = r; dir = d;
    @(posedge clk); #2;
  endtask

  int nwrap;
  int rc;
  bit rr, rd, re;

  initial begin
    // Reset
    rst = 1; en = 1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_locked",   32'(o_locked),    0);
    check("rst_expected", 32'(o_expected),  0);
    check("rst_errcnt",   32'(o_err_count), 0);
    rst = 0;

    // 1: count up 0..9; idle edge first, then acquire at 0
    step(1, 0, 0, 0);
    for (int i = 0; i <= 9; i++) begin
      step(1, i, 0, 0);
      if (i == 3) check("s1_nolock3", 32'(o_locked), 0);
      if (i == 4) check("s1_lock4",   32'(o_locked), 1);
    end
    check("s1_errcnt", 32'(o_err_count), 0);

    // 2: continue up through the wrap
    nwrap = 0;
    for (int i = 10; i <= 255 + 2; i++) begin
      step(1, i % 256, 0, 0);
      if (i >= 253 && o_wrap) nwrap++;
      if (i == 256) check("s2_wrap_at0", 32'(o_wrap), 1);
    end
    check("s2_one_wrap", 32'(nwrap), 1);
    check("s2_errcnt",   32'(o_err_count), 0);

    // 3: skip 12
    for (int i = 2; i <= 11; i++) step(1, i, 0, 0);
    step(1, 13, 0, 0);
    check("s3_err13",    32'(o_error), 1);
    check("s3_errcnt",   32'(o_err_count), 1);
    step(1, 14, 0, 0);
    check("s3_unlock",   32'(o_locked), 0);
    step(1, 15, 0, 0);
    step(1, 16, 0, 0);
    step(1, 17, 0, 0);
`ifdef COUNT_CHECKER_STOP_ON_ERR_EN
    check("s3_frozen",   32'(o_expected), 12);
    check("s3_norelock", 32'(o_locked), 0);
    check("s3_errhold",  32'(o_err_count), 1);
`else
    check("s3_relock17", 32'(o_locked), 1);
    check("s3_exp18",    32'(o_expected), 18);
`endif

    // 4: disable, reacquire, tm_reset at 37 then count down
    step(0, 30, 0, 0);
    step(1, 30, 0, 0);
    for (int i = 30; i <= 36; i++) step(1, i, 0, 0);
    step(1, 37, 1, 0);
    check("s4_exp0", 32'(o_expected), 0);
    step(1, 0, 0, 1);
    check("s4_nowrap0", 32'(o_wrap), 0);
    step(1, 255, 0, 1);
    check("s4_wrap255", 32'(o_wrap), 1);
    step(1, 254, 0, 1);
    check("s4_noerr",   32'(o_error), 0);

    // 5: stuck at 5, direction up
    for (int i = 0; i < 300; i++) step(1, 5, 0, 0);
`ifndef COUNT_CHECKER_STOP_ON_ERR_EN
    check("s5_sat",     32'(o_err_count), 255);
    check("s5_errpulse", 32'(o_error), 1);
`endif

    // Random: counter with glitches, tm_reset, direction changes, dropouts
    step(0, 0, 0, 0);
    rc = 0;
    for (int i = 0; i < 3000; i++) begin
      re = ($urandom_range(0, 49) != 0);
      rr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) rd = ~rd;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1; step(re, rc, rr, rd); rst = 0; rc = 0;
      end else begin
        step(re, rc, rr, rd);
        rc = predict(rc, rr, rd);
        if ($urandom_range(0, 24) == 0) rc = int'($urandom_range(0, MAXV));
      end
    end

    // 6: reset mid-TRACK at 100
    step(0, 0, 0, 0);
    step(1, 90, 0, 0);
    for (int i = 90; i <= 100; i++) step(1, i, 0, 0);
    rst = 1;
    step(1, 101, 0, 0);
    rst = 0;
    check("s6_locked",   32'(o_locked),    0);
    check("s6_error",    32'(o_error),     0);
    check("s6_wrap",     32'(o_wrap),      0);
    check("s6_expected", 32'(o_expected),  0);
    check("s6_errcnt",   32'(o_err_count), 0);
    // First enabled edge after reset is the idle edge: no compare yet
    step(1, 77, 0, 0);
    check("s6_idle_noerr", 32'(o_error), 0);
    step(1, 78, 0, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
